// File: rtl/pdm_mic_emulator.sv
// PDM MEMS microphone emulator: sine tone from a phase accumulator and a 64-entry LUT,
// converted to a 1-bit stream by a first-order sigma-delta, clocked out on mic_clk edges.
module pdm_mic_emulator #(
    parameter int PHASE_W  = 24,
    parameter int SAMPLE_W = 10,
    parameter int CNT_W    = 16
) (
    input  logic               clk_100,
    input  logic               rst_n,
    input  logic               mic_clk,
    input  logic               micLRSel,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [7:0]         amplitude,
    output logic               micData,
    output logic               micData_oe,
    output logic [CNT_W-1:0]   bit_count
);

    localparam logic [SAMPLE_W-1:0] MID_SCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic               mic_clk_s1, mic_clk_s2, mic_clk_s3;
    logic               rise, fall, sel_edge;
    logic [PHASE_W-1:0] phase;
    logic [SAMPLE_W-1:0] acc;
    logic signed [9:0]  lut_val;
    logic [SAMPLE_W-1:0] u_val;
    logic [SAMPLE_W:0]  sum;

    // Quarter-wave table mirrored into a full period: round(511*sin(2*pi*i/64)).
    function automatic logic signed [9:0] sine_lut(input logic [5:0] idx);
        logic [4:0] k;
        logic [9:0] mag;
        k = idx[4] ? 5'(6'd32 - {1'b0, idx[4:0]}) : idx[4:0];
        case (k)
            5'd0:    mag = 10'd0;
            5'd1:    mag = 10'd50;
            5'd2:    mag = 10'd100;
            5'd3:    mag = 10'd148;
            5'd4:    mag = 10'd196;
            5'd5:    mag = 10'd241;
            5'd6:    mag = 10'd284;
            5'd7:    mag = 10'd324;
            5'd8:    mag = 10'd361;
            5'd9:    mag = 10'd395;
            5'd10:   mag = 10'd425;
            5'd11:   mag = 10'd451;
            5'd12:   mag = 10'd472;
            5'd13:   mag = 10'd489;
            5'd14:   mag = 10'd501;
            5'd15:   mag = 10'd509;
            5'd16:   mag = 10'd511;
            default: mag = 10'd0;
        endcase
        sine_lut = idx[5] ? (10'sd0 - $signed(mag)) : $signed(mag);
    endfunction

    // Gain with arithmetic floor shift, then offset to unsigned mid-scale.
    function automatic logic [SAMPLE_W-1:0] scale_offset(input logic signed [9:0] lut,
                                                         input logic [7:0] gain);
        logic signed [18:0] prod;
        logic [SAMPLE_W-1:0] scaled;
        prod   = $signed({{9{lut[9]}}, lut}) * $signed({11'd0, gain});
        scaled = SAMPLE_W'(prod >>> 8);
        scale_offset = scaled + MID_SCALE;
    endfunction

    assign rise     = mic_clk_s2 & ~mic_clk_s3;
    assign fall     = ~mic_clk_s2 & mic_clk_s3;
    assign sel_edge = micLRSel ? fall : rise;

    assign lut_val = sine_lut(phase[PHASE_W-1 -: 6]);
    assign u_val   = scale_offset(lut_val, amplitude);
    assign sum     = {1'b0, acc} + {1'b0, u_val};

    // Stage boundary: synchroniser, generator state and output bit all update on clk_100.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            mic_clk_s1 <= 1'b0;
            mic_clk_s2 <= 1'b0;
            mic_clk_s3 <= 1'b0;
            phase      <= '0;
            acc        <= '0;
            micData    <= 1'b0;
            micData_oe <= 1'b0;
            bit_count  <= '0;
        end else begin
            mic_clk_s1 <= mic_clk;
            mic_clk_s2 <= mic_clk_s1;
            mic_clk_s3 <= mic_clk_s2;
            micData_oe <= enable;
            if (!enable) begin
                micData <= 1'b0;
            end else if (sel_edge) begin
                micData   <= sum[SAMPLE_W];
                acc       <= sum[SAMPLE_W-1:0];
                phase     <= phase + phase_inc;
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

endmodule
